// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS frequency word K from start to stop, holding each value for a fixed dwell.
// Define DDS_SWEEP_TRI_EN to build the triangle (up then down) sweep; otherwise cfg_tri is ignored.
module dds_sweep_ctrl #(
   parameter int KW = 32,
   parameter int PW = 11,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [KW-1:0] cfg_start_k,
   input  logic [KW-1:0] cfg_stop_k,
   input  logic [KW-1:0] cfg_step_k,
   input  logic [DW-1:0] cfg_dwell,
   input  logic [PW-1:0] cfg_phase,
   input  logic          cfg_tri,
   input  logic          start,
   input  logic          abort,
   output logic [KW-1:0] K,
   output logic [PW-1:0] P,
   output logic          k_upd,
   output logic          busy,
   output logic          done
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DWELL, S_STEP, S_DONE} state_t;
   state_t state, state_nxt;

   logic [KW-1:0] start_q, stop_q, step_q;
   logic [DW-1:0] dwell_q;
   logic [PW-1:0] phase_q;

   logic [DW-1:0] cnt, cnt_nxt, dw_last;
   logic [KW-1:0] k_nxt;
   logic [PW-1:0] p_nxt;
   logic          upd_nxt;
   logic [KW:0]   up_sum;
   logic          up_clamp, at_top;

   assign cfg_ready = (state == S_IDLE);
   assign busy      = (state == S_LOAD) || (state == S_DWELL) || (state == S_STEP);
   assign done      = (state == S_DONE);

   // The counter holds remaining cycles after the current one, so a dwell of 0 or 1 expires at once.
   assign dw_last  = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
   assign up_sum   = {1'b0, K} + {1'b0, step_q};
   assign up_clamp = (step_q == '0) || up_sum[KW] || (up_sum >= {1'b0, stop_q});
   assign at_top   = (K >= stop_q);

`ifdef DDS_SWEEP_TRI_EN
   logic          tri_q, dir, dir_nxt;
   logic [KW:0]   dn_diff;
   logic          dn_clamp, at_bot;

   assign dn_diff  = {1'b0, K} - {1'b0, step_q};
   assign dn_clamp = (step_q == '0) || dn_diff[KW] || (dn_diff[KW-1:0] <= start_q);
   assign at_bot   = (K <= start_q);
`else
   logic unused_tri;
   assign unused_tri = cfg_tri;
`endif

   always_comb begin
      state_nxt = state;
      k_nxt     = K;
      p_nxt     = P;
      cnt_nxt   = cnt;
      upd_nxt   = 1'b0;
`ifdef DDS_SWEEP_TRI_EN
      dir_nxt   = dir;
`endif
      case (state)
         S_IDLE: if (start) state_nxt = S_LOAD;
         S_LOAD: begin
            k_nxt     = start_q;
            p_nxt     = phase_q;
            upd_nxt   = 1'b1;
            cnt_nxt   = dw_last;
            state_nxt = S_DWELL;
`ifdef DDS_SWEEP_TRI_EN
            dir_nxt   = 1'b0;
`endif
         end
         // STEP is the first cycle of a new value's dwell, so it counts exactly like DWELL.
         S_DWELL, S_STEP: begin
            if (cnt != '0) begin
               cnt_nxt   = cnt - DW'(1);
               state_nxt = S_DWELL;
            end else begin
               cnt_nxt   = dw_last;
               state_nxt = S_STEP;
               upd_nxt   = 1'b1;
`ifdef DDS_SWEEP_TRI_EN
               if (dir) begin
                  if (at_bot) begin
                     state_nxt = S_DONE;
                     upd_nxt   = 1'b0;
                  end else
                     k_nxt = dn_clamp ? start_q : dn_diff[KW-1:0];
               end else if (!at_top)
                  k_nxt = up_clamp ? stop_q : up_sum[KW-1:0];
               else if (tri_q && (start_q < stop_q)) begin
                  dir_nxt = 1'b1;
                  k_nxt   = dn_clamp ? start_q : dn_diff[KW-1:0];
               end else begin
                  state_nxt = S_DONE;
                  upd_nxt   = 1'b0;
               end
`else
               if (!at_top)
                  k_nxt = up_clamp ? stop_q : up_sum[KW-1:0];
               else begin
                  state_nxt = S_DONE;
                  upd_nxt   = 1'b0;
               end
`endif
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         k_nxt     = '0;
         upd_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         K     <= '0;
         P     <= '0;
         k_upd <= 1'b0;
         cnt   <= '0;
`ifdef DDS_SWEEP_TRI_EN
         dir   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         K     <= k_nxt;
         P     <= p_nxt;
         k_upd <= upd_nxt;
         cnt   <= cnt_nxt;
`ifdef DDS_SWEEP_TRI_EN
         dir   <= dir_nxt;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         phase_q <= '0;
`ifdef DDS_SWEEP_TRI_EN
         tri_q   <= 1'b0;
`endif
      end else if (cfg_valid && cfg_ready) begin
         start_q <= cfg_start_k;
         stop_q  <= cfg_stop_k;
         step_q  <= cfg_step_k;
         dwell_q <= cfg_dwell;
         phase_q <= cfg_phase;
`ifdef DDS_SWEEP_TRI_EN
         tri_q   <= cfg_tri;
`endif
      end
   end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected K updates and done strobes are queued with the gap
// in cycles from the previous event; a negedge monitor pops and compares each one the DUT presents.
module tb_dds_sweep_ctrl;
   logic        clk = 1'b0;
   logic        rst, cfg_valid, cfg_ready, cfg_tri, start, abort;
   logic [31:0] cfg_start_k, cfg_stop_k, cfg_step_k, K;
   logic [15:0] cfg_dwell;
   logic [10:0] cfg_phase, P;
   logic        k_upd, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_done;
      logic [31:0] k;
      logic [10:0] p;
      int          gap;
   } ev_t;
   ev_t sb[$];

   dds_sweep_ctrl dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_start_k(cfg_start_k), .cfg_stop_k(cfg_stop_k), .cfg_step_k(cfg_step_k),
      .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase), .cfg_tri(cfg_tri),
      .start(start), .abort(abort), .K(K), .P(P), .k_upd(k_upd), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int last = 0;
   always @(negedge clk) begin
      ev_t e;
      cyc++;
      if (!rst && (k_upd || done)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: k_upd=%0b done=%0b K=%h", k_upd, done, K);
         end else begin
            e = sb.pop_front();
            if ((e.is_done != done) || (!e.is_done && (K !== e.k || P !== e.p)) ||
                (e.gap != 0 && (cyc - last) != e.gap)) begin
               errors++;
               $display("FAIL event: got done=%0b K=%h P=%h gap=%0d, expected done=%0b K=%h P=%h gap=%0d",
                        done, K, P, cyc - last, e.is_done, e.k, e.p, e.gap);
            end
         end
         last = cyc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_k(input logic [31:0] k, input logic [10:0] p, input int gap);
      ev_t e;
      e.is_done = 1'b0; e.k = k; e.p = p; e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic push_done(input int gap);
      ev_t e;
      e.is_done = 1'b1; e.k = '0; e.p = '0; e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic cfg_write(input logic [31:0] sk, input logic [31:0] ek, input logic [31:0] st,
                            input logic [15:0] dw, input logic [10:0] ph, input logic tr);
      @(posedge clk); #1;
      chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
      cfg_start_k = sk; cfg_stop_k = ek; cfg_step_k = st;
      cfg_dwell = dw; cfg_phase = ph; cfg_tri = tr; cfg_valid = 1'b1;
      @(posedge clk); #1 cfg_valid = 1'b0;
   endtask

   task automatic go();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic drain(input logic [31:0] kf);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d events outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk); #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_K", K, kf);
   endtask

   task automatic up_sweep_100_400();
      push_k(32'd100, 11'd5, 0);
      push_k(32'd200, 11'd5, 3);
      push_k(32'd300, 11'd5, 3);
      push_k(32'd400, 11'd5, 3);
      push_done(3);
   endtask

   initial begin
      int n;
      rst = 1'b1; cfg_valid = 1'b0; cfg_tri = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_start_k = '0; cfg_stop_k = '0; cfg_step_k = '0; cfg_dwell = '0; cfg_phase = '0;
      #2;
      chk("rst_K", K, 32'd0);
      chk("rst_P", {21'd0, P}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Basic up sweep: total 12 cycles from first k_upd to done.
      cfg_write(32'd100, 32'd400, 32'd100, 16'd3, 11'd5, 1'b0);
      up_sweep_100_400();
      go();
      drain(32'd400);
      chk("up_P", {21'd0, P}, 32'd5);

      // Clamp at stop.
      cfg_write(32'd0, 32'd250, 32'd100, 16'd1, 11'd9, 1'b0);
      push_k(32'd0, 11'd9, 0); push_k(32'd100, 11'd9, 1);
      push_k(32'd200, 11'd9, 1); push_k(32'd250, 11'd9, 1); push_done(1);
      go();
      drain(32'd250);

      // Carry out of the adder must clamp, never wrap.
      cfg_write(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1, 11'd9, 1'b0);
      push_k(32'hFFFF_FF00, 11'd9, 0); push_k(32'hFFFF_FF80, 11'd9, 1);
      push_k(32'hFFFF_FFFF, 11'd9, 1); push_done(1);
      go();
      drain(32'hFFFF_FFFF);

      // start >= stop: single value, no step.
      cfg_write(32'd500, 32'd200, 32'd10, 16'd2, 11'd1, 1'b0);
      push_k(32'd500, 11'd1, 0); push_done(2);
      go();
      drain(32'd500);

      // step = 0 jumps straight to stop.
      cfg_write(32'd10, 32'd50, 32'd0, 16'd2, 11'd1, 1'b0);
      push_k(32'd10, 11'd1, 0); push_k(32'd50, 11'd1, 2); push_done(2);
      go();
      drain(32'd50);

      // Config offered while busy is dropped; a restart reuses the old config.
      cfg_write(32'd100, 32'd400, 32'd100, 16'd3, 11'd5, 1'b0);
      up_sweep_100_400();
      go();
      @(posedge clk); #1;
      cfg_start_k = 32'd7; cfg_stop_k = 32'd8; cfg_step_k = 32'd1; cfg_dwell = 16'd1;
      cfg_phase = 11'd77; cfg_valid = 1'b1;
      chk("busy_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      @(posedge clk); #1 cfg_valid = 1'b0;
      drain(32'd400);
      up_sweep_100_400();
      go();
      drain(32'd400);

      // dwell = 0 behaves as 1.
      cfg_write(32'd7, 32'd9, 32'd1, 16'd0, 11'd3, 1'b0);
      push_k(32'd7, 11'd3, 0); push_k(32'd8, 11'd3, 1); push_k(32'd9, 11'd3, 1); push_done(1);
      go();
      drain(32'd9);

      // Triangle sweep (up-only when the feature is not built).
      cfg_write(32'd100, 32'd300, 32'd100, 16'd2, 11'd4, 1'b1);
      push_k(32'd100, 11'd4, 0); push_k(32'd200, 11'd4, 2); push_k(32'd300, 11'd4, 2);
`ifdef DDS_SWEEP_TRI_EN
      push_k(32'd200, 11'd4, 2); push_k(32'd100, 11'd4, 2); push_done(2);
      go();
      drain(32'd100);
`else
      push_done(2);
      go();
      drain(32'd300);
`endif

      // Abort during the second dwell, with start high the same cycle.
      cfg_write(32'd100, 32'd400, 32'd100, 16'd3, 11'd5, 1'b0);
      push_k(32'd100, 11'd5, 0); push_k(32'd200, 11'd5, 3);
      go();
      n = 0;
      while (K !== 32'd200 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reach_200", K, 32'd200);
      @(posedge clk); #1 abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      chk("abort_K", K, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      abort = 1'b0; start = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("abort_no_events", sb.size(), 32'd0);
      chk("abort_stay_K", K, 32'd0);
      chk("abort_P_held", {21'd0, P}, 32'd5);
      chk("abort_stay_idle", {31'd0, busy}, 32'd0);

      // Reset mid-sweep clears everything, including the shadow config.
      cfg_write(32'd100, 32'd400, 32'd100, 16'd3, 11'd5, 1'b0);
      push_k(32'd100, 11'd5, 0);
      go();
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_K", K, 32'd0);
      chk("midrst_P", {21'd0, P}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      chk("midrst_sb_empty", sb.size(), 32'd0);
      sb.delete();
      @(posedge clk); #1 rst = 1'b0;

      // Start with no config since reset: 0..0 for one cycle, then done.
      push_k(32'd0, 11'd0, 0); push_done(1);
      go();
      drain(32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
